// File: rtl/lfsr_chk.sv
// lfsr_chk: serial PRBS checker.
// It fills a shadow LFSR from the incoming stream and verifies it against the predicted next bit.
// It declares lock after LOCK_CNT consecutive matches.
// While locked it counts mismatches and drops lock after UNLOCK_ERRS accumulated errors.
// Optional feature, macro LFSR_CHK_FLYWHEEL_EN: while locked, the shadow register
// free-runs on its own prediction, so a single corrupted bit yields exactly one error.
`timescale 1ns/1ps

module lfsr_chk #(
  parameter int LFSR_W      = 16,
  parameter int FULL_SEQ    = 1,
  parameter int LOCK_CNT    = 32,
  parameter int UNLOCK_ERRS = 4,
  parameter int ERR_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             bit_i,
  input  logic             clr_i,
  output logic             lock_o,
  output logic             err_o,
  output logic [ERR_W-1:0] err_cnt_o
);

  // Feedback tap set for each width from the XAPP052 table.
  // Tap n of the table sits at shadow bit n-1, and shadow bit 0 holds the newest bit.
  function automatic logic [31:0] tap_mask(input int w);
    logic [31:0] m;
    m = 32'h0;
    case (w)
      3:  m = 32'h0000_0006;
      4:  m = 32'h0000_000C;
      5:  m = 32'h0000_0014;
      6:  m = 32'h0000_0030;
      7:  m = 32'h0000_0060;
      8:  m = 32'h0000_00B8;
      9:  m = 32'h0000_0110;
      10: m = 32'h0000_0240;
      11: m = 32'h0000_0500;
      12: m = 32'h0000_0829;
      13: m = 32'h0000_100D;
      14: m = 32'h0000_2015;
      15: m = 32'h0000_6000;
      16: m = 32'h0000_D008;
      17: m = 32'h0001_2000;
      18: m = 32'h0002_0400;
      19: m = 32'h0004_0023;
      20: m = 32'h0009_0000;
      21: m = 32'h0014_0000;
      22: m = 32'h0030_0000;
      23: m = 32'h0042_0000;
      24: m = 32'h00E1_0000;
      25: m = 32'h0120_0000;
      26: m = 32'h0200_0023;
      27: m = 32'h0400_0013;
      28: m = 32'h0900_0000;
      29: m = 32'h1400_0000;
      30: m = 32'h2000_0029;
      31: m = 32'h4800_0000;
      32: m = 32'h8020_0003;
      default: m = 32'h0;
    endcase
    return m;
  endfunction

  localparam logic [31:0]       TAP_MASK_32 = tap_mask(LFSR_W);
  localparam logic [LFSR_W-1:0] TAPS        = TAP_MASK_32[LFSR_W-1:0];

  localparam int FILL_W  = (LFSR_W      < 2) ? 1 : $clog2(LFSR_W + 1);
  localparam int MATCH_W = (LOCK_CNT    < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam int ACC_W   = (UNLOCK_ERRS < 2) ? 1 : $clog2(UNLOCK_ERRS + 1);

  localparam logic [FILL_W-1:0]  FILL_LAST   = FILL_W'(LFSR_W - 1);
  localparam logic [MATCH_W-1:0] MATCH_LOCK  = MATCH_W'(LOCK_CNT);
  localparam logic [ACC_W-1:0]   ACC_UNLOCK  = ACC_W'(UNLOCK_ERRS);

  typedef enum logic [1:0] {
    FILL   = 2'b00,
    VERIFY = 2'b01,
    LOCKED = 2'b10
  } state_t;

  state_t             state;
  logic [LFSR_W-1:0]  shadow;
  logic [FILL_W-1:0]  fill_cnt;
  logic [MATCH_W-1:0] match_cnt;
  logic [ACC_W-1:0]   acc_cnt;

  logic               predict;
  logic               mismatch;
  logic               locked_in;
  logic [MATCH_W-1:0] match_next;
  logic [ACC_W-1:0]   acc_next;

  // Predicted next bit: XNOR of the taps; full-length mode folds in the all-ones extension term.
  always_comb begin
    predict = ~(^(shadow & TAPS));
    if (FULL_SEQ != 0) begin
      predict = predict ^ (&shadow[LFSR_W-2:0]);
    end
    mismatch   = bit_i ^ predict;
    match_next = match_cnt + MATCH_W'(1);
    acc_next   = acc_cnt + ACC_W'(1);
  end

`ifdef LFSR_CHK_FLYWHEEL_EN
  // Once locked the shadow register free-runs on its own prediction, so line errors never enter it.
  assign locked_in = predict;
`else
  // The shadow register always follows the line, so a corrupted bit is later seen again at the taps.
  assign locked_in = bit_i;
`endif

  // Checker state machine: fill, verify, locked; also owns the registered lock, error pulse and error count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= FILL;
      shadow    <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      acc_cnt   <= '0;
      lock_o    <= 1'b0;
      err_o     <= 1'b0;
      err_cnt_o <= '0;
    end else begin
      err_o <= 1'b0;
      if (en_i) begin
        case (state)
          FILL: begin
            shadow <= {shadow[LFSR_W-2:0], bit_i};
            if (fill_cnt == FILL_LAST) begin
              fill_cnt  <= '0;
              match_cnt <= '0;
              state     <= VERIFY;
            end else begin
              fill_cnt <= fill_cnt + FILL_W'(1);
            end
          end
          VERIFY: begin
            shadow <= {shadow[LFSR_W-2:0], bit_i};
            if (mismatch) begin
              match_cnt <= '0;
            end else if (match_next == MATCH_LOCK) begin
              match_cnt <= '0;
              acc_cnt   <= '0;
              lock_o    <= 1'b1;
              state     <= LOCKED;
            end else begin
              match_cnt <= match_next;
            end
          end
          LOCKED: begin
            shadow <= {shadow[LFSR_W-2:0], locked_in};
            if (mismatch) begin
              err_o     <= 1'b1;
              match_cnt <= '0;
              if (err_cnt_o != {ERR_W{1'b1}}) begin
                err_cnt_o <= err_cnt_o + ERR_W'(1);
              end
              if (acc_next == ACC_UNLOCK) begin
                acc_cnt  <= '0;
                fill_cnt <= '0;
                lock_o   <= 1'b0;
                state    <= FILL;
              end else begin
                acc_cnt <= acc_next;
              end
            end else if (match_next == MATCH_LOCK) begin
              match_cnt <= '0;
              acc_cnt   <= '0;
            end else begin
              match_cnt <= match_next;
            end
          end
          default: begin
            fill_cnt  <= '0;
            match_cnt <= '0;
            acc_cnt   <= '0;
            lock_o    <= 1'b0;
            state     <= FILL;
          end
        endcase
      end
      if (clr_i) begin
        err_cnt_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_chk.sv
// tb_lfsr_chk: scoreboard bench for lfsr_chk.
// It compares two instances that differ only in error counter width against a
// behavioural model of the checking rules, and adds directed checks on lock timing.
`timescale 1ns/1ps

module tb_lfsr_chk;

  localparam int W      = 4;
  localparam int LOCK   = 8;
  localparam int UNLOCK = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       bit_in;
  logic       clr;
  logic       lock8;
  logic       err8;
  logic [7:0] cnt8;
  logic       lock2;
  logic       err2;
  logic [1:0] cnt2;

  lfsr_chk #(.LFSR_W(W), .FULL_SEQ(1), .LOCK_CNT(LOCK), .UNLOCK_ERRS(UNLOCK), .ERR_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .bit_i(bit_in), .clr_i(clr),
    .lock_o(lock8), .err_o(err8), .err_cnt_o(cnt8)
  );

  lfsr_chk #(.LFSR_W(W), .FULL_SEQ(1), .LOCK_CNT(LOCK), .UNLOCK_ERRS(UNLOCK), .ERR_W(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .en_i(en), .bit_i(bit_in), .clr_i(clr),
    .lock_o(lock2), .err_o(err2), .err_cnt_o(cnt2)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit lock;
    bit err;
    int cnt8;
    int cnt2;
  } exp_t;

  typedef enum int {M_FILL, M_VERIFY, M_LOCKED} mphase_e;

  exp_t    sbq[$];
  bit      gHist[$];
  bit      mHist[$];
  mphase_e mPhase;
  int      mFillSeen, mRun, mAcc, mCnt8, mCnt2;
  bit      mLock, mErr;

  int assertCount = 0;
  int failCount   = 0;
  bit obsLock, obsLock2, obsErr;
  int obsCnt, obsCnt2;
  int errPulses;

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // The sequence rule: XNOR of taps 4 and 3, with the extension term when the three newest bits are all ones.
  function automatic bit prbsRule(input bit s0, input bit s1, input bit s2, input bit s3);
    return (~(s3 ^ s2)) ^ (s0 & s1 & s2);
  endfunction

  function automatic bit nextGenBit();
    bit b;
    b = prbsRule(gHist[0], gHist[1], gHist[2], gHist[3]);
    gHist.push_front(b);
    void'(gHist.pop_back());
    return b;
  endfunction

  function automatic void modelReset();
    mPhase    = M_FILL;
    mFillSeen = 0;
    mRun      = 0;
    mAcc      = 0;
    mCnt8     = 0;
    mCnt2     = 0;
    mLock     = 1'b0;
    mErr      = 1'b0;
    mHist.delete();
    repeat (W) mHist.push_back(1'b0);
  endfunction

  function automatic void modelStep(input bit enV, input bit b, input bit clrV);
    bit p;
    bit shiftIn;
    mErr = 1'b0;
    if (enV) begin
      p = prbsRule(mHist[0], mHist[1], mHist[2], mHist[3]);
      shiftIn = b;
      case (mPhase)
        M_FILL: begin
          mFillSeen++;
          if (mFillSeen == W) begin
            mPhase    = M_VERIFY;
            mFillSeen = 0;
            mRun      = 0;
          end
        end
        M_VERIFY: begin
          mRun = (b == p) ? mRun + 1 : 0;
          if (mRun == LOCK) begin
            mPhase = M_LOCKED;
            mLock  = 1'b1;
            mRun   = 0;
            mAcc   = 0;
          end
        end
        default: begin
`ifdef LFSR_CHK_FLYWHEEL_EN
          shiftIn = p;
`endif
          if (b != p) begin
            mErr  = 1'b1;
            mCnt8 = (mCnt8 + 1 > 255) ? 255 : mCnt8 + 1;
            mCnt2 = (mCnt2 + 1 > 3) ? 3 : mCnt2 + 1;
            mAcc++;
            mRun  = 0;
            if (mAcc == UNLOCK) begin
              mPhase    = M_FILL;
              mLock     = 1'b0;
              mAcc      = 0;
              mFillSeen = 0;
            end
          end else begin
            mRun++;
            if (mRun % LOCK == 0) mAcc = 0;
          end
        end
      endcase
      mHist.push_front(shiftIn);
      void'(mHist.pop_back());
    end
    if (clrV) begin
      mCnt8 = 0;
      mCnt2 = 0;
    end
  endfunction

  task automatic applyStimulus(input bit enV, input bit bitV, input bit clrV);
    exp_t e;
    @(negedge clk);
    #1;
    en     = enV;
    bit_in = bitV;
    clr    = clrV;
    modelStep(enV, bitV, clrV);
    e.lock = mLock;
    e.err  = mErr;
    e.cnt8 = mCnt8;
    e.cnt2 = mCnt2;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    obsLock  = lock8;
    obsLock2 = lock2;
    obsErr   = err8;
    obsCnt   = int'(cnt8);
    obsCnt2  = int'(cnt2);
    if (err8) errPulses++;
  endtask

  task automatic sendBit(input bit flip, input bit clrV);
    bit g;
    g = nextGenBit();
    applyStimulus(1'b1, g ^ flip, clrV);
  endtask

  task automatic syncLock(input string tag, output int nBits);
    nBits = 0;
    while (!obsLock && nBits < 40) begin
      sendBit(1'b0, 1'b0);
      nBits++;
    end
    if (!obsLock) checkOutput({tag, " lock timeout"}, 0, 1);
  endtask

  // Monitor: every clocked expectation is compared on the falling edge after the edge it describes.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checkOutput("lock_o", int'(lock8), int'(e.lock));
        checkOutput("err_o", int'(err8), int'(e.err));
        checkOutput("err_cnt_o", int'(cnt8), e.cnt8);
        checkOutput("sat lock_o", int'(lock2), int'(e.lock));
        checkOutput("sat err_o", int'(err2), int'(e.err));
        checkOutput("sat err_cnt_o", int'(cnt2), e.cnt2);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nBits;
    int fallAt;
    bit g;
    bit enR;
    bit clrR;
    bit flipR;

    rst = 1'b1; en = 1'b0; bit_in = 1'b0; clr = 1'b0;
    gHist.delete();
    repeat (W) gHist.push_back(1'b0);
    modelReset();
    obsLock = 1'b0; obsErr = 1'b0; errPulses = 0;

    repeat (3) @(negedge clk);
    checkOutput("reset lock_o", int'(lock8), 0);
    checkOutput("reset err_o", int'(err8), 0);
    checkOutput("reset err_cnt_o", int'(cnt8), 0);
    checkOutput("reset sat err_cnt_o", int'(cnt2), 0);
    #1 rst = 1'b0;

    $display("[TB] clean stream: lock after fill plus %0d matches", LOCK);
    syncLock("initial", nBits);
    checkOutput("initial lock bit index", nBits, 12);
    repeat (200 - nBits) sendBit(1'b0, 1'b0);
    checkOutput("clean err pulses", errPulses, 0);
    checkOutput("clean err_cnt_o", obsCnt, 0);

    $display("[TB] single corrupted bit");
    errPulses = 0;
    sendBit(1'b1, 1'b0);
    checkOutput("single err on flipped edge", int'(obsErr), 1);
    repeat (20) sendBit(1'b0, 1'b0);
`ifdef LFSR_CHK_FLYWHEEL_EN
    checkOutput("single err pulses", errPulses, 1);
    checkOutput("single err_cnt_o", obsCnt, 1);
    checkOutput("single lock held", int'(obsLock), 1);
`endif

    $display("[TB] inverted stream");
    syncLock("pre-invert", nBits);
    sendBit(1'b0, 1'b1);
    errPulses = 0;
    fallAt = 0;
    for (int i = 1; i <= 6; i++) begin
      sendBit(1'b1, 1'b0);
      if (!obsLock && fallAt == 0) fallAt = i;
    end
`ifdef LFSR_CHK_FLYWHEEL_EN
    checkOutput("invert lock fall index", fallAt, 4);
    checkOutput("invert err pulses", errPulses, 4);
    checkOutput("invert err_cnt_o", obsCnt, 4);
`endif

    $display("[TB] spaced errors against a 2-bit counter");
    syncLock("post-invert", nBits);
    sendBit(1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      sendBit(1'b1, 1'b0);
      repeat (15) sendBit(1'b0, 1'b0);
    end
`ifdef LFSR_CHK_FLYWHEEL_EN
    checkOutput("spaced sat err_cnt_o", obsCnt2, 3);
    checkOutput("spaced wide err_cnt_o", obsCnt, 5);
    checkOutput("spaced sat lock held", int'(obsLock2), 1);
`endif

    $display("[TB] clear coinciding with a mismatch");
    syncLock("pre-clear", nBits);
    sendBit(1'b1, 1'b1);
    checkOutput("clear+err err_o", int'(obsErr), 1);
    checkOutput("clear+err err_cnt_o", obsCnt, 0);

    $display("[TB] enable held low while locked");
    syncLock("pre-hold", nBits);
    errPulses = 0;
    repeat (30) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    checkOutput("hold lock_o", int'(obsLock), 1);
    checkOutput("hold err pulses", errPulses, 0);

    $display("[TB] randomized enable, corruption and clear");
    for (int i = 0; i < 400; i++) begin
      enR   = ($urandom_range(0, 3) != 0);
      clrR  = ($urandom_range(0, 49) == 0);
      flipR = ($urandom_range(0, 29) == 0);
      if (enR) begin
        g = nextGenBit();
        applyStimulus(1'b1, g ^ flipR, clrR);
      end else begin
        applyStimulus(1'b0, 1'($urandom_range(0, 1)), clrR);
      end
    end

    $display("[TB] asynchronous reset while locked");
    syncLock("pre-reset", nBits);
    sendBit(1'b1, 1'b0);
    @(negedge clk);
    #1;
    en  = 1'b0;
    clr = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("async reset lock_o", int'(lock8), 0);
    checkOutput("async reset err_cnt_o", int'(cnt8), 0);
    checkOutput("async reset sat err_cnt_o", int'(cnt2), 0);
    #1 rst = 1'b0;
    modelReset();
    obsLock = 1'b0;
    syncLock("relock", nBits);
    checkOutput("relock bit index", nBits, 12);

    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("scoreboard drained", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
